// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq
//   Sequences a shared combinational ALU between two requesters. A request
//   (op, a, b) is accepted over valid/ready, registered onto the ALU inputs,
//   held for SETTLE_CYCLES, and the ALU result is captured and returned with
//   the winning requester's id over a valid/ready response channel.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (0/1)
//   reqN_op/a/b              requester N opcode and operands (DW bits)
//   alu_a/alu_b/alu_op       registered drive to the external ALU
//   alu_result               ALU output (RW bits)
//   rsp_valid/ready          response handshake
//   rsp_data/rsp_id          captured result and issuing requester
//   busy                     high whenever an operation is in flight
module alu_arbiter_seq #(
  parameter int unsigned DW            = 4,
  parameter int unsigned RW            = 8,
  parameter int unsigned SETTLE_CYCLES = 1   // legal range 1..15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] alu_op,
  input  logic [RW-1:0] alu_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [RW-1:0] rsp_data,
  output logic          rsp_id,
  output logic          busy
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic       r_id;
  logic       r_last;      // requester served most recently
  logic       w_any;
  logic       w_grant;
  logic       w_accept;

  // Grant: on a tie the requester that did not win last time is served;
  // a lone valid is served regardless of the pointer.
  always_comb begin
    w_any      = req0_valid | req1_valid;
    w_grant    = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    w_accept   = (r_state == IDLE) & w_any;
    req0_ready = w_accept & req0_valid & ~w_grant;
    req1_ready = w_accept & req1_valid &  w_grant;
    busy       = (r_state != IDLE);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)          w_state_nxt = WAIT;
      WAIT:    if (r_cnt == 4'd1)  w_state_nxt = RESP;
      RESP:    if (rsp_ready)      w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Reset pointer = 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      r_cnt     <= '0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            alu_a  <= w_grant ? req1_a  : req0_a;
            alu_b  <= w_grant ? req1_b  : req0_b;
            alu_op <= w_grant ? req1_op : req0_op;
            r_id   <= w_grant;
            r_cnt  <= SETTLE_INIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            rsp_data  <= alu_result;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_last    <= r_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter_seq.md
Name: alu_arbiter_seq

Overview:
- Sequences the shared 4-bit ALU (alu: datain1, datain2, op_code → 8-bit out) and arbitrates it between two requesters.
- Each requester issues (op, a, b) over a valid/ready handshake. The block registers the operands onto the ALU inputs, waits a fixed settle time, captures the 8-bit result, and returns it with the winner's id over a valid/ready response channel.
- Sits between the instruction/control logic and the combinational ALU. The ALU is instantiated alongside this block, not inside it.

Parameters:
- DW, 4, operand and opcode width (matches ALU datain/op_code).
- RW, 8, ALU result width.
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before the result is captured; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  DW  requester 0 opcode.
- req0_a  in  DW  requester 0 operand 1.
- req0_b  in  DW  requester 0 operand 2.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- alu_a  out  DW  registered, to ALU datain1.
- alu_b  out  DW  registered, to ALU datain2.
- alu_op  out  DW  registered, to ALU op_code.
- alu_result  in  RW  from ALU out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  RW  captured result.
- rsp_id  out  1  requester that issued the result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (async, immediate): state IDLE; alu_a/alu_b/alu_op 0; rsp_valid 0; rsp_data 0; rsp_id 0; busy 0; round-robin pointer set so requester 0 wins the first tie.
- States:
  - IDLE: grant = RR winner among asserted valids; reqN_ready = (state==IDLE) & (grant==N), combinational, at most one high. On handshake: alu_a/alu_b/alu_op <= winner's fields, id <= N, counter <= SETTLE_CYCLES, go to WAIT.
  - WAIT: ALU inputs held stable; counter decrements each cycle. In the cycle counter==1: rsp_data <= alu_result, rsp_id <= id, rsp_valid <= 1, go to RESP.
  - RESP: rsp_valid, rsp_data and rsp_id held stable. On rsp_valid & rsp_ready: rsp_valid <= 0, RR pointer <= id (the other requester gets priority next), go to IDLE.
- Latency: handshake in cycle t → rsp_valid first high in cycle t+1+SETTLE_CYCLES. Minimum issue interval is SETTLE_CYCLES+2 cycles.
- Arbitration:
  - Both valid in IDLE → the requester that did not win last is served.
  - Only one valid → that requester is served regardless of the pointer.
  - No valid → stay in IDLE; ALU registers keep their last values.
- Requesters hold valid and fields until ready. Dropping valid before ready is allowed and simply withdraws the request.
- No new request is accepted while in WAIT or RESP; both readys are low.
- Backpressure: rsp_ready low holds RESP indefinitely; the result does not change.
- rsp_ready high in the first RESP cycle → IDLE next cycle; no bubble beyond that.
- Widths: no arithmetic inside the block; the result is captured unmodified at RW bits.
- Reset asserted mid-operation (WAIT or RESP): the in-flight operation is discarded and no response is produced after reset.

Test Plan:
(Bench ALU stub: alu_result = {alu_a, alu_b}; SETTLE_CYCLES=1 unless stated.)
- Single op: req0 op=4'b0011 a=3 b=2 → req0_ready same cycle; alu_op=3, alu_a=3, alu_b=2 next cycle; rsp_valid 2 cycles after handshake with rsp_data=8'h32, rsp_id=0.
- Contention: req0 and req1 both valid from reset (req0 a=3 b=2; req1 op=4'b0100 a=5 b=1) with rsp_ready=1 → req0 served first (rsp 8'h32, id 0), then req1 (rsp 8'h51, id 1); three-op stream alternates ids 0,1,0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_data/rsp_id stable, both readys low, busy=1; release → IDLE next cycle.
- Settle: SETTLE_CYCLES=4, req1 op=4'b0101 a=3 b=2 → ALU inputs stable for 4 cycles; rsp_valid at handshake+5 with rsp_data=8'h32.
- Reset mid-WAIT: assert rst one cycle after handshake → all outputs 0 immediately; no rsp_valid after release until a new request is issued.
- Withdrawn request: req1_valid pulsed for 1 cycle while busy → never granted; no response with id 1.
